or16_frame_accum: RTL and testbench
===================================

// Module: or16_frame_accum
// PURPOSE
//  Consumes the 16-bit word stream produced by the Or16 datapath stage and ORs successive
//  words into one 16-bit mask per frame.
//  A frame closes after FRAME_LEN accepted words, or earlier on in_last.
//  The closed mask and its word count are then held on a valid/ready output port until
//  downstream accepts them.
//  Typical uses: sticky status/flag collection and interrupt-mask build-up.
// PARAMETERS
//  FRAME_LEN  8                          words per frame; legal range 1..255
//  CNT_W      $clog2(FRAME_LEN+1)        width of word counter and out_count (localparam)
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      in_data valid this cycle
//  in_ready   out  1      block can accept in_data this cycle
//  in_data    in   16     word to OR into current frame
//  in_last    in   1      qualified by in_valid: this beat closes the frame early
//  out_valid  out  1      out_mask/out_count hold a closed frame
//  out_ready  in   1      downstream accepts the frame this cycle
//  out_mask   out  16     OR of all words in the closed frame
//  out_count  out  CNT_W  number of words in the closed frame (1..FRAME_LEN)
// BEHAVIOUR
//  - Clocking/reset: one clock, clk. reset is synchronous, active-high and sampled on posedge clk.
//  - Reset values: state=IDLE, acc=0, cnt=0, out_valid=0, out_mask=0, out_count=0.
//    Reset has priority over every other event, so a partial frame is discarded mid-frame.
//  - Handshakes:
//    - Input beat accepted when in_valid && in_ready.
//    - Output accepted when out_valid && out_ready.
//    - in_ready = (state!=HOLD), combinational from state only; it is 1 in the cycle after reset.
//  - States:
//    - IDLE: acc=0, cnt=0. An accepted beat goes to ACCUM with acc=in_data, cnt=1.
//      If that beat also closes the frame, go directly to HOLD.
//    - ACCUM: an accepted beat sets acc|=in_data and cnt+=1.
//    - Close condition on an accepted beat: (cnt+1==FRAME_LEN) || in_last.
//      On close: out_mask<=acc|in_data, out_count<=cnt+1, out_valid<=1, acc<=0, cnt<=0,
//      state->HOLD.
//    - HOLD: out_mask/out_count are held stable while out_valid=1.
//      When the output is accepted: out_valid<=0, state->IDLE.
//  - Latency: the closing beat is accepted at edge N; out_valid=1 from edge N to the next
//    accepting edge. Minimum output occupancy is 1 cycle.
//  - FRAME_LEN=1: every accepted word closes a frame with out_count=1.
//  - Idle cycles (in_valid=0) never advance cnt or modify acc.
//  - in_last on a beat that also reaches FRAME_LEN is one close, not two.
//  - out_mask/out_count keep their last values after acceptance until the next close.
//  - Counter never wraps: it clears on every close, and cnt < FRAME_LEN always holds in ACCUM.
//  - Stalled inputs: in_data/in_last are don't-care when in_valid=0 or in_ready=0.
// CONFIGURATION
//  OR16_ACCUM_PASSTHRU_EN
//   - Defined: in_ready = (state!=HOLD) || out_ready.
//     In HOLD, if output acceptance and an input beat occur in the same cycle, the old frame
//     retires and the beat starts a new frame (acc=in_data, cnt=1, state->ACCUM).
//     If that beat also closes a frame, the new mask loads and the block stays in HOLD
//     with out_valid=1.
//     Result: full throughput, no bubble.
//   - Undefined: in_ready=0 throughout HOLD. One bubble cycle per frame after acceptance.
// TESTING
//  1. FRAME_LEN=4; 0x0001,0x0010,0x0100,0x1000 back-to-back, out_ready=1
//     -> out_valid=1 the cycle after the 4th accept, out_mask=0x1111, out_count=4.
//  2. 0x8000 then 0x0001 with in_last -> out_mask=0x8001, out_count=2.
//     Next frame 0x0002 x4 -> out_mask=0x0002 (no leakage from the prior frame).
//  3. Frame closed with out_ready=0 for 5 cycles -> out_valid/out_mask/out_count stable and
//     in_ready=0 for all 5 cycles; in_valid pulses during that window are not counted.
//  4. reset for 1 cycle after 2 beats of 0xFFFF, then 4 beats of 0x0000
//     -> out_mask=0x0000, out_count=4.
//  5. in_valid toggles 1,0,0,1,0,1,1 with 0x0004 each time (FRAME_LEN=4)
//     -> close on the 4th valid beat, out_count=4.
//  6. With out_valid=1, drive out_ready=1 and in_valid=1 (0x0020) in the same cycle.
//     Macro defined -> beat accepted, the next frame carries 0x0020.
//     Macro undefined -> in_ready=0 that cycle and the beat is held by the source.

Source files
------------

// File: rtl/or16_frame_accum.sv
// ORs accepted 16-bit words into one mask per frame (FRAME_LEN words or early in_last); mask+count held on valid/ready.
// Optional OR16_ACCUM_PASSTHRU_EN lets a new beat enter in the same cycle the held frame retires (no bubble).
module or16_frame_accum #(
  parameter  int FRAME_LEN = 8,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_mask,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [15:0]        r_out_mask;
  logic [CNT_W-1:0]   r_out_count;

  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_close;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [15:0]        w_mask;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_mask     = r_acc | in_data;
  // acc/cnt sit at zero outside ACCUM, so one close rule covers every state
  assign w_close    = w_in_fire && ((w_cnt_inc == CNT_W'(FRAME_LEN)) || in_last);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_in_fire) w_state_nxt = w_close ? S_HOLD : S_ACCUM;
      end
      S_HOLD: begin
        if (w_out_fire) begin
          if (w_close)        w_state_nxt = S_HOLD;
          else if (w_in_fire) w_state_nxt = S_ACCUM;
          else                w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef OR16_ACCUM_PASSTHRU_EN
    in_ready = (r_state != S_HOLD) || out_ready;
`else
    in_ready = (r_state != S_HOLD);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_count <= '0;
    end else begin
      r_out_valid <= (w_state_nxt == S_HOLD);
      if (w_close) begin
        r_out_mask  <= w_mask;
        r_out_count <= w_cnt_inc;
        r_acc       <= '0;
        r_cnt       <= '0;
      end else if (w_in_fire) begin
        r_acc <= w_mask;
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_mask  = r_out_mask;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_or16_frame_accum.sv
// Directed checks of or16_frame_accum with FRAME_LEN=4; honours OR16_ACCUM_PASSTHRU_EN when defined.
module tb_or16_frame_accum;

  localparam int FL = 4;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_mask;
  logic [CW-1:0] out_count;

  int checks = 0;
  int errors = 0;

  or16_frame_accum #(.FRAME_LEN(FL)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'hDEAD;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_mask !== 16'h0) begin errors++; $display("FAIL reset_out_mask got %h want 0000", out_mask); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", out_count); end
  endtask

  task automatic test_full_frame();
    out_ready = 1'b1;
    send(16'h0001, 1'b0); send(16'h0010, 1'b0); send(16'h0100, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %b want 0", out_valid); end
    send(16'h1000, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", out_valid); end
    checks++; if (out_mask !== 16'h1111) begin errors++; $display("FAIL full_mask got %h want 1111", out_mask); end
    checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", out_count); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_retire got %b want 0", out_valid); end
    checks++; if (out_mask !== 16'h1111) begin errors++; $display("FAIL full_mask_kept got %h want 1111", out_mask); end
  endtask

  task automatic test_early_last();
    send(16'h8000, 1'b0); send(16'h0001, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL last_valid got %b want 1", out_valid); end
    checks++; if (out_mask !== 16'h8001) begin errors++; $display("FAIL last_mask got %h want 8001", out_mask); end
    checks++; if (out_count !== 3'd2) begin errors++; $display("FAIL last_count got %0d want 2", out_count); end
    accept();
    for (int i = 0; i < 4; i++) send(16'h0002, 1'b0);
    checks++; if (out_mask !== 16'h0002) begin errors++; $display("FAIL noleak_mask got %h want 0002", out_mask); end
    checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL noleak_count got %0d want 4", out_count); end
    accept();
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 4; i++) send(16'h00F0, 1'b0);
    in_valid = 1'b1; in_data = 16'hFFFF; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_mask !== 16'h00F0 || out_count !== 3'd4) begin
        errors++; $display("FAIL stall_hold cyc %0d got v=%b m=%h c=%0d want v=1 m=00f0 c=4", i, out_valid, out_mask, out_count);
      end
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    accept();
    send(16'h0001, 1'b1);
    checks++; if (out_mask !== 16'h0001 || out_count !== 3'd1) begin
      errors++; $display("FAIL stall_nocount got m=%h c=%0d want m=0001 c=1", out_mask, out_count);
    end
    accept();
  endtask

  task automatic test_mid_reset();
    send(16'hFFFF, 1'b0); send(16'hFFFF, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_state got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    send(16'h0000, 1'b0); send(16'h0000, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_partial got %b want 0", out_valid); end
    send(16'h0000, 1'b0); send(16'h0000, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_mask !== 16'h0000 || out_count !== 3'd4) begin
      errors++; $display("FAIL midrst_frame got v=%b m=%h c=%0d want v=1 m=0000 c=4", out_valid, out_mask, out_count);
    end
    accept();
  endtask

  task automatic test_gaps();
    logic [6:0] pat;
    pat = 7'b1101001;  // bit i = in_valid for cycle i
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      in_data  = pat[i] ? 16'h0004 : 16'hFFFF;
      in_last  = 1'b0;
      step();
      if (i == 5) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gaps_early got %b want 0", out_valid); end
      end
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_mask !== 16'h0004 || out_count !== 3'd4) begin
      errors++; $display("FAIL gaps_frame got v=%b m=%h c=%0d want v=1 m=0004 c=4", out_valid, out_mask, out_count);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    send(16'h0100, 1'b1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0020; in_last = 1'b0;
    #1;
`ifdef OR16_ACCUM_PASSTHRU_EN
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
    step();
`else
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_bubble got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    step();
`endif
    in_valid = 1'b0; out_ready = 1'b0;
    send(16'h0000, 1'b1);
    checks++; if (out_mask !== 16'h0020 || out_count !== 3'd2) begin
      errors++; $display("FAIL b2b_next got m=%h c=%0d want m=0020 c=2", out_mask, out_count);
    end
`ifdef OR16_ACCUM_PASSTHRU_EN
    out_ready = 1'b1;
    send(16'h0400, 1'b1);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_mask !== 16'h0400 || out_count !== 3'd1) begin
      errors++; $display("FAIL b2b_reclose got v=%b m=%h c=%0d want v=1 m=0400 c=1", out_valid, out_mask, out_count);
    end
`endif
    accept();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_early_last();
    test_hold_stall();
    test_mid_reset();
    test_gaps();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
